// File: rtl/seq_detect_ctrl_pkg.sv
// rtl/seq_detect_ctrl_pkg.sv - shared encodings, defaults and detector next-state helper
package seq_detect_ctrl_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;
  localparam int TOT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } ctrl_state_e;

  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    S3,
    S4
  } det_state_e;

  function automatic det_state_e det_next(input det_state_e s, input logic b);
    det_state_e n;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S1 : S3;
      S3:      n = b ? S4 : S0;
      S4:      n = b ? S1 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - word handshake bundle between producer and controller
interface seq_detect_ctrl_if #(
  parameter int WORD_W = seq_detect_ctrl_pkg::WORD_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              keep_hist;

  modport master (
    output in_valid,
    output in_data,
    output keep_hist,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  keep_hist,
    output in_ready
  );

endinterface

// File: rtl/pattern_1001_det.sv
// rtl/pattern_1001_det.sv - Moore detector for serial 1001 with overlap
module pattern_1001_det
  import seq_detect_ctrl_pkg::*;
(
  input  logic Clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic I,
  output logic F
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      state_d = det_next(state_q, I);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign F = (state_q == S4);

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - serialises words MSB-first into the 1001 detector and counts hits
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TOT_W  = TOT_W_DEF
) (
  input  logic             Clk,
  input  logic             reset,
  seq_detect_ctrl_if.slave in_if,
  output logic             busy,
  output logic             match_pulse,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic [TOT_W-1:0] total_matches
);

  localparam int              BC_W    = $clog2(WORD_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

  ctrl_state_e       state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOT_W-1:0]  tot_q, tot_d;
  logic              in_ready_c;
  logic              det_clr, det_en, det_f, sample;

  pattern_1001_det u_det (
    .Clk   (Clk),
    .reset (reset),
    .clr   (det_clr),
    .en    (det_en),
    .I     (sh_q[WORD_W-1]),
    .F     (det_f)
  );

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bc_d       = bc_q;
    cnt_d      = cnt_q;
    tot_d      = tot_q;
    in_ready_c = 1'b0;
    det_clr    = 1'b0;
    det_en     = 1'b0;
    sample     = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = !reset;
        if (in_if.in_valid && !reset) begin
          sh_d    = in_if.in_data;
          bc_d    = '0;
          cnt_d   = '0;
          det_clr = !in_if.keep_hist;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        det_en = 1'b1;
        // In the first shift cycle F still shows the previous word's last state, already counted
        sample = (bc_q != '0);
        sh_d   = sh_q << 1;
        bc_d   = bc_q + BC_W'(1);
        if (bc_q == BC_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        sample  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    match_pulse = sample && det_f;
    if (match_pulse) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (tot_q != '1) tot_d = tot_q + TOT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bc_q    <= '0;
      cnt_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bc_q    <= bc_d;
      cnt_q   <= cnt_d;
      tot_q   <= tot_d;
    end
  end

  assign in_if.in_ready = in_ready_c;
  assign busy           = (state_q == SHIFT) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign match_count    = cnt_q;
  assign total_matches  = tot_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - randomized self-checking bench with a bit-history reference model
module tb_seq_detect_ctrl;

  localparam int W = 8;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy, match_pulse, done;
  logic [3:0]  mc;
  logic [15:0] tot;
  logic        busy2, match_pulse2, done2;
  logic [3:0]  mc2;
  logic [1:0]  tot2;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  seq_detect_ctrl_if #(.WORD_W(W)) bus ();
  seq_detect_ctrl_if #(.WORD_W(W)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.keep_hist = bus.keep_hist;

  seq_detect_ctrl #(.WORD_W(W), .CNT_W(4), .TOT_W(16)) dut (
    .Clk           (Clk),
    .reset         (reset),
    .in_if         (bus.slave),
    .busy          (busy),
    .match_pulse   (match_pulse),
    .done          (done),
    .match_count   (mc),
    .total_matches (tot)
  );

  seq_detect_ctrl #(.WORD_W(W), .CNT_W(4), .TOT_W(2)) dut_sat (
    .Clk           (Clk),
    .reset         (reset),
    .in_if         (bus2.slave),
    .busy          (busy2),
    .match_pulse   (match_pulse2),
    .done          (done2),
    .match_count   (mc2),
    .total_matches (tot2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a detection is simply "the last four bits fed since the last clear were 1001"
  bit         m_init = 1'b0;
  int         m_k = 0;
  logic [W-1:0] m_word = '0;
  logic [3:0] m_hist = '0;
  int         m_n = 0;
  int         m_cnt = 0, m_tot = 0, m_tot2 = 0;

  initial begin
    bit busy_e, done_e, rdy_e, samp, pulse_e;
    forever begin
      @(negedge Clk);
      pulse_e = 1'b0;
      if (m_init) begin
        busy_e  = (m_k >= 1) && (m_k <= W + 1);
        done_e  = (m_k == W + 2);
        rdy_e   = (m_k == 0) && !reset;
        samp    = (m_k >= 2) && (m_k <= W + 1);
        pulse_e = samp && (m_n >= 4) && (m_hist == 4'b1001);
        chk("in_ready", 32'(bus.in_ready), 32'(rdy_e));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("done", 32'(done), 32'(done_e));
        chk("match_pulse", 32'(match_pulse), 32'(pulse_e));
        chk("match_count", 32'(mc), 32'(m_cnt));
        chk("total_matches", 32'(tot), 32'(m_tot));
        chk("sat_in_ready", 32'(bus2.in_ready), 32'(rdy_e));
        chk("sat_done", 32'(done2), 32'(done_e));
        chk("sat_match_count", 32'(mc2), 32'(m_cnt));
        chk("sat_total", 32'(tot2), 32'(m_tot2));
      end
      if (reset) begin
        m_init = 1'b1;
        m_k = 0; m_hist = '0; m_n = 0;
        m_cnt = 0; m_tot = 0; m_tot2 = 0;
      end else if (m_init) begin
        if (pulse_e) begin
          m_cnt  = (m_cnt  < 15)    ? m_cnt + 1  : 15;
          m_tot  = (m_tot  < 65535) ? m_tot + 1  : 65535;
          m_tot2 = (m_tot2 < 3)     ? m_tot2 + 1 : 3;
        end
        if (m_k == 0) begin
          if (bus.in_valid) begin
            m_word = bus.in_data;
            m_cnt  = 0;
            if (!bus.keep_hist) begin
              m_hist = '0; m_n = 0;
            end
            m_k = 1;
          end
        end else if (m_k <= W) begin
          m_hist = {m_hist[2:0], m_word[W-m_k]};
          m_n    = (m_n < 4) ? m_n + 1 : 4;
          m_k++;
        end else if (m_k == W + 1) begin
          m_k++;
        end else begin
          m_k = 0;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input bit keep, input bit hold,
                      output int done_at, output logic [31:0] pmask);
    done_at = -1;
    pmask   = '0;
    @(posedge Clk); #1;
    bus.in_valid = 1'b1; bus.in_data = w; bus.keep_hist = keep;
    @(posedge Clk); #1;
    if (!hold) bus.in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (hold) begin
        bus.in_data = W'($urandom); bus.keep_hist = 1'($urandom);
      end
      @(negedge Clk);
      if (match_pulse) pmask[n] = 1'b1;
      if (done) begin
        done_at = n;
        break;
      end
      @(posedge Clk); #1;
    end
    bus.in_valid = 1'b0;
    if (done_at < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got none expected done within 20 cycles");
    end
  endtask

  initial begin
    int          d;
    logic [31:0] pm;
    int          seen;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.keep_hist = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 reset = 1'b0;
    @(negedge Clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(mc), 32'd0);
    chk("rst_total", 32'(tot), 32'd0);

    send(8'b10010000, 1'b0, 1'b0, d, pm);
    chk("w1_done_cycle", 32'(d), 32'd10);
    chk("w1_pulses", pm, 32'h20);
    chk("w1_count", 32'(mc), 32'd1);
    chk("w1_total", 32'(tot), 32'd1);

    send(8'b10010011, 1'b0, 1'b0, d, pm);
    chk("overlap_pulses", pm, 32'h120);
    chk("overlap_count", 32'(mc), 32'd2);
    chk("overlap_total", 32'(tot), 32'd3);

    send(8'b00000010, 1'b0, 1'b0, d, pm);
    chk("cross_a_count", 32'(mc), 32'd0);
    send(8'b01000000, 1'b1, 1'b0, d, pm);
    chk("cross_keep_count", 32'(mc), 32'd1);
    chk("cross_keep_pulses", pm, 32'h8);

    send(8'b00000010, 1'b0, 1'b0, d, pm);
    send(8'b01000000, 1'b0, 1'b0, d, pm);
    chk("cross_clr_count", 32'(mc), 32'd0);

    send(8'b10010000, 1'b0, 1'b1, d, pm);
    chk("hold_done_cycle", 32'(d), 32'd10);
    chk("hold_count", 32'(mc), 32'd1);
    chk("hold_total", 32'(tot), 32'd5);

    @(posedge Clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'b10011001; bus.keep_hist = 1'b0;
    @(posedge Clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1 reset = 1'b1;
    @(posedge Clk); #1 reset = 1'b0;
    @(negedge Clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(mc), 32'd0);
    chk("midrst_total", 32'(tot), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge Clk);
      if (done) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    send(8'b10010000, 1'b1, 1'b0, d, pm);
    chk("post_rst_count", 32'(mc), 32'd1);
    chk("post_rst_pulses", pm, 32'h20);

    repeat (3) send(8'b10010000, 1'b0, 1'b0, d, pm);
    chk("sat_total_lit", 32'(tot2), 32'd3);
    chk("sat_count_lit", 32'(mc2), 32'd1);
    chk("nosat_total_lit", 32'(tot), 32'd4);

    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), d, pm);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end
    repeat (2) @(posedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
